// File: rtl/cart_mapper_if.sv
// Cartridge mapper bus: CPU address/strobe, loader write port, ROM and Superchip outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; the CPU strobe and loader write are single-cycle pulses.
interface cart_mapper_if;
  logic [12:0] cpu_addr_i;
  logic        cpu_rnw_i;
  logic        cpu_strobe_i;
  logic        mode_f8_i;
  logic        sc_enable_i;
  logic        load_we_i;
  logic [14:0] load_addr_i;
  logic [14:0] rom_addr_o;
  logic [2:0]  bank_o;
  logic [2:0]  rom_size_o;
  logic        sc_rd_sel_o;
  logic        sc_we_o;
  logic [6:0]  sc_addr_o;

  // Mapper side
  modport slave (
    input  cpu_addr_i, cpu_rnw_i, cpu_strobe_i, mode_f8_i, sc_enable_i,
           load_we_i, load_addr_i,
    output rom_addr_o, bank_o, rom_size_o, sc_rd_sel_o, sc_we_o, sc_addr_o
  );

  // CPU / loader side
  modport master (
    output cpu_addr_i, cpu_rnw_i, cpu_strobe_i, mode_f8_i, sc_enable_i,
           load_we_i, load_addr_i,
    input  rom_addr_o, bank_o, rom_size_o, sc_rd_sel_o, sc_we_o, sc_addr_o
  );
endinterface

// File: rtl/cart_mapper.sv
// Atari-style cartridge bank mapper (F8/FE/F6/F4) with image-size detection.
// Latency: bank and rom_size register one clk_i after strobe/load; ROM address and Superchip selects are combinational.
// Backpressure: none. Optional Superchip RAM decode is compiled in by macro CART_SUPERCHIP_EN.
module cart_mapper (
  input  logic          clk_i,
  input  logic          rst_ni,
  cart_mapper_if.slave  cart_io
);

  logic [2:0] bank_q, bank_d;
  // Size is never reset: the image is loaded while the CPU sits in reset.
  logic [2:0] rom_size_q = 3'b000;
  logic [2:0] rom_size_d;

  logic [12:0] addr;
  logic        hot_vld;
  logic [2:0]  hot_bank;
  logic [2:0]  bank_mask;

  assign addr = cart_io.cpu_addr_i;

  // Size detection: an image write at offset 0 starts a new image; high address bits mark its extent.
  always_comb begin
    rom_size_d = rom_size_q;
    if (cart_io.load_we_i) begin
      if (cart_io.load_addr_i[13:0] == 14'd0) rom_size_d = 3'b000;
      rom_size_d = rom_size_d | {cart_io.load_addr_i[14], cart_io.load_addr_i[13],
                                 cart_io.load_addr_i[12]};
    end
  end

  // Hotspot decode against the current (pre-update) size, full 13-bit address match.
  always_comb begin
    hot_vld  = 1'b0;
    hot_bank = 3'd0;
    if (cart_io.cpu_strobe_i) begin
      case (rom_size_q)
        3'b001: begin
          if (cart_io.mode_f8_i) begin
            if (addr == 13'h1FF8) begin hot_vld = 1'b1; hot_bank = 3'd0; end
            if (addr == 13'h1FF9) begin hot_vld = 1'b1; hot_bank = 3'd1; end
          end else begin
            if (addr == 13'h01FE) begin hot_vld = 1'b1; hot_bank = 3'd0; end
            if (addr == 13'h11FE) begin hot_vld = 1'b1; hot_bank = 3'd1; end
          end
        end
        3'b011: begin
          if (addr >= 13'h1FF6 && addr <= 13'h1FF9) begin
            hot_vld  = 1'b1;
            hot_bank = {1'b0, addr[1:0] - 2'd2};
          end
        end
        3'b111: begin
          if (addr >= 13'h1FF4 && addr <= 13'h1FFB) begin
            hot_vld  = 1'b1;
            hot_bank = addr[2:0] - 3'd4;
          end
        end
        default: hot_vld = 1'b0;
      endcase
    end
  end

  // Clamp the bank to the range of the scheme that will be active next cycle.
  always_comb begin
    case (rom_size_d)
      3'b001:  bank_mask = 3'b001;
      3'b011:  bank_mask = 3'b011;
      default: bank_mask = 3'b111;
    endcase
    bank_d = (hot_vld ? hot_bank : bank_q) & bank_mask;
  end

  // Bank register: reset wins over any hotspot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) bank_q <= 3'd0;
    else         bank_q <= bank_d;
  end

  // Size register: follows loader writes regardless of reset.
  always_ff @(posedge clk_i) begin
    rom_size_q <= rom_size_d;
  end

  assign cart_io.bank_o     = bank_q;
  assign cart_io.rom_size_o = rom_size_q;
  assign cart_io.rom_addr_o = {bank_q, addr[11:0]};

`ifdef CART_SUPERCHIP_EN
  // Superchip: write port $1000-$107F, read port $1080-$10FF.
  assign cart_io.sc_rd_sel_o = cart_io.sc_enable_i & addr[12] & (addr[11:8] == 4'd0) & addr[7];
  assign cart_io.sc_we_o     = cart_io.sc_enable_i & cart_io.cpu_strobe_i & ~cart_io.cpu_rnw_i
                               & addr[12] & (addr[11:7] == 5'd0);
  assign cart_io.sc_addr_o   = addr[6:0];
`else
  logic unused_sc;
  assign unused_sc           = cart_io.sc_enable_i ^ cart_io.cpu_rnw_i;
  assign cart_io.sc_rd_sel_o = 1'b0;
  assign cart_io.sc_we_o     = 1'b0;
  assign cart_io.sc_addr_o   = 7'd0;
`endif

endmodule

// File: tb/tb_cart_mapper.sv
// Directed bench for cart_mapper with an expectation queue drained after each step.
// Latency: registered outputs checked #1 after the edge, combinational outputs checked mid-cycle.
// Backpressure: none.
module tb_cart_mapper;
  logic clk_i = 1'b0;
  logic rst_ni;

  cart_mapper_if cart_io ();

  cart_mapper dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cart_io(cart_io.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {K_BANK, K_SIZE, K_ROMA, K_SCWE, K_SCRD, K_SCAD} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [14:0] val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_val(input string tag, input kind_e kind, input logic [14:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [14:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_BANK:  obs = {12'd0, cart_io.bank_o};
        K_SIZE:  obs = {12'd0, cart_io.rom_size_o};
        K_ROMA:  obs = cart_io.rom_addr_o;
        K_SCWE:  obs = {14'd0, cart_io.sc_we_o};
        K_SCRD:  obs = {14'd0, cart_io.sc_rd_sel_o};
        default: obs = {8'd0, cart_io.sc_addr_o};
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock edge, then return pulses to idle and check registered results.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cart_io.cpu_strobe_i = 1'b0;
    cart_io.load_we_i    = 1'b0;
    drain();
  endtask

  task automatic cpu(input logic [12:0] a, input logic stb, input logic rnw);
    cart_io.cpu_addr_i   = a;
    cart_io.cpu_strobe_i = stb;
    cart_io.cpu_rnw_i    = rnw;
  endtask

  task automatic load(input logic [14:0] a);
    cart_io.load_we_i   = 1'b1;
    cart_io.load_addr_i = a;
  endtask

  initial begin
    rst_ni               = 1'b0;
    cart_io.cpu_addr_i   = 13'h0000;
    cart_io.cpu_rnw_i    = 1'b1;
    cart_io.cpu_strobe_i = 1'b0;
    cart_io.mode_f8_i    = 1'b1;
    cart_io.sc_enable_i  = 1'b0;
    cart_io.load_we_i    = 1'b0;
    cart_io.load_addr_i  = 15'h0000;
    #1;
    expect_val("powerup_size", K_SIZE, 15'd0);
    drain();

    // Reset and image load while held in reset
    cpu(13'h0123, 1'b0, 1'b1);
    expect_val("reset_bank", K_BANK, 15'd0);
    tick();
    expect_val("reset_romaddr", K_ROMA, 15'h0123);
    drain();
    load(15'h0000); tick();
    load(15'h7FFF); expect_val("size_32k", K_SIZE, 15'd7); tick();
    load(15'h0000); expect_val("size_clear", K_SIZE, 15'd0); tick();
    rst_ni = 1'b1;
    load(15'h3000); expect_val("size_16k", K_SIZE, 15'd3); tick();

    // F6
    cpu(13'h1FF8, 1'b1, 1'b1);
    #1; expect_val("f6_old_bank_read", K_ROMA, 15'h0FF8); drain();
    expect_val("f6_1ff8_bank", K_BANK, 15'd2); tick();
    expect_val("f6_1ff8_romaddr", K_ROMA, 15'h2FF8); drain();
    cpu(13'h1FF9, 1'b0, 1'b1); expect_val("f6_nostrobe", K_BANK, 15'd2); tick();
    cpu(13'h1FF9, 1'b1, 1'b1); expect_val("f6_1ff9", K_BANK, 15'd3); tick();
    cpu(13'h1FF7, 1'b1, 1'b1); expect_val("f6_1ff7", K_BANK, 15'd1); tick();
    cpu(13'h1FF5, 1'b1, 1'b1); expect_val("f6_nonhot", K_BANK, 15'd1); tick();

    // F8 / FE
    load(15'h0000); tick();
    load(15'h1000); expect_val("size_8k", K_SIZE, 15'd1); tick();
    cart_io.mode_f8_i = 1'b0;
    cpu(13'h01FE, 1'b1, 1'b1); expect_val("fe_01fe", K_BANK, 15'd0); tick();
    cpu(13'h11FE, 1'b1, 1'b1); expect_val("fe_11fe", K_BANK, 15'd1); tick();
    cpu(13'h1FF8, 1'b1, 1'b1); expect_val("fe_ignores_f8", K_BANK, 15'd1); tick();
    cart_io.mode_f8_i = 1'b1;
    cpu(13'h1FF8, 1'b1, 1'b0); expect_val("f8_write_1ff8", K_BANK, 15'd0); tick();
    cpu(13'h1FF9, 1'b1, 1'b1); expect_val("f8_1ff9", K_BANK, 15'd1); tick();
    cpu(13'h1FF6, 1'b1, 1'b1); expect_val("f8_nonhot", K_BANK, 15'd1); tick();

    // Size 000 holds bank
    load(15'h0000); expect_val("size_4k", K_SIZE, 15'd0); tick();
    cpu(13'h1FF8, 1'b1, 1'b1); expect_val("4k_hold", K_BANK, 15'd1); tick();

    // F4 and reset priority
    load(15'h7000); tick();
    cpu(13'h1FF9, 1'b1, 1'b1); expect_val("f4_1ff9", K_BANK, 15'd5); tick();
    cpu(13'h0000, 1'b0, 1'b1); rst_ni = 1'b0;
    expect_val("rst_bank", K_BANK, 15'd0); expect_val("rst_keeps_size", K_SIZE, 15'd7); tick();
    rst_ni = 1'b1;
    cpu(13'h1FFB, 1'b1, 1'b1); expect_val("f4_1ffb", K_BANK, 15'd7); tick();
    cpu(13'h1FF4, 1'b1, 1'b1); rst_ni = 1'b0;
    expect_val("rst_over_hotspot", K_BANK, 15'd0); tick();
    rst_ni = 1'b1;
    cpu(13'h1FFB, 1'b1, 1'b1); tick();
    cpu(13'h1FFC, 1'b1, 1'b1); expect_val("f4_nonhot", K_BANK, 15'd7); tick();

    // Load and hotspot together: decode uses old size
    cpu(13'h1FF5, 1'b1, 1'b1); load(15'h0000);
    expect_val("both_bank", K_BANK, 15'd1); expect_val("both_size", K_SIZE, 15'd0); tick();

    // Bank clamped when the scheme shrinks
    load(15'h7000); tick();
    cpu(13'h1FFB, 1'b1, 1'b1); tick();
    load(15'h0000); expect_val("hold_7_in_4k", K_BANK, 15'd7); tick();
    load(15'h1000); expect_val("clamp_to_8k", K_BANK, 15'd1); tick();

    // Superchip decode
    cart_io.sc_enable_i = 1'b1;
    cpu(13'h1005, 1'b1, 1'b0);
    #1;
    expect_val("romaddr_comb", K_ROMA, 15'h1005);
`ifdef CART_SUPERCHIP_EN
    expect_val("sc_we_write", K_SCWE, 15'd1);
    expect_val("sc_addr_write", K_SCAD, 15'd5);
    expect_val("sc_rd_on_write", K_SCRD, 15'd0);
`else
    expect_val("sc_we_write", K_SCWE, 15'd0);
    expect_val("sc_addr_write", K_SCAD, 15'd0);
    expect_val("sc_rd_on_write", K_SCRD, 15'd0);
`endif
    drain();
    tick();
    cpu(13'h1085, 1'b1, 1'b1);
    #1;
`ifdef CART_SUPERCHIP_EN
    expect_val("sc_rd_read", K_SCRD, 15'd1);
`else
    expect_val("sc_rd_read", K_SCRD, 15'd0);
`endif
    expect_val("sc_we_read", K_SCWE, 15'd0);
    drain();
    tick();
    cpu(13'h1005, 1'b0, 1'b0);
    #1;
    expect_val("sc_we_nostrobe", K_SCWE, 15'd0);
    drain();
    cart_io.sc_enable_i = 1'b0;
    cpu(13'h1005, 1'b1, 1'b0);
    #1;
    expect_val("sc_we_disabled", K_SCWE, 15'd0);
    drain();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cart_mapper.md
CART_MAPPER -- requirements
Module: cart_mapper

Interface
REQ-001 clk_i  in  1  system clock (clk_sys domain); all state on rising edge.
REQ-002 rst_ni  in  1  reset; synchronous and active-low.
REQ-003 cpu_addr_i  in  13  CPU address bits [12:0].
REQ-004 cpu_rnw_i  in  1  CPU read-not-write.
REQ-005 cpu_strobe_i  in  1  one-clk_i pulse per CPU cycle, marking the stable-address point.
REQ-006 mode_f8_i  in  1  8K scheme select: 1 = F8, 0 = FE.
REQ-007 sc_enable_i  in  1  Superchip RAM enable (cpu control register bit 2).
REQ-008 load_we_i  in  1  cartridge image byte write from the SPI loader.
REQ-009 load_addr_i  in  15  image byte address of that write.
REQ-010 rom_addr_o  out  15  ROM read address {bank, cpu_addr_i[11:0]}.
REQ-011 bank_o  out  3  current bank.
REQ-012 rom_size_o  out  3  detected size code: 000 = 4K or less, 001 = 8K, 011 = 16K, 111 = 32K.
REQ-013 sc_rd_sel_o  out  1  CPU is reading the Superchip read port.
REQ-014 sc_we_o  out  1  Superchip RAM write enable.
REQ-015 sc_addr_o  out  7  Superchip RAM address = cpu_addr_i[6:0].

Function
REQ-016 On a load_we_i cycle with load_addr_i[13:0] == 0, rom_size SHALL clear to 000.
- In the same cycle, each of load_addr_i bits 12, 13 and 14 that is 1 SHALL set rom_size bit 0, 1 and 2 respectively.
- A set bit takes priority over the clear.
REQ-017 rom_size SHALL update one clk_i after the load write; it changes only on load writes.
REQ-018 Hotspots are evaluated only in cycles where cpu_strobe_i = 1, on reads and writes alike.
REQ-019 Size 001 with mode_f8_i = 1 (F8): address $1FF8 SHALL select bank 0; $1FF9 SHALL select bank 1.
REQ-020 Size 001 with mode_f8_i = 0 (FE): address $01FE SHALL select bank 0; $11FE SHALL select bank 1.
REQ-021 Size 011 (F6): addresses $1FF6..$1FF9 SHALL select banks 0..3.
REQ-022 Size 111 (F4): addresses $1FF4..$1FFB SHALL select banks 0..7.
REQ-023 Size 000 (or any other code): bank SHALL hold its value; no hotspots are active.
REQ-024 bank_o SHALL update one clk_i after the qualifying strobe.
REQ-025 rom_addr_o SHALL be combinational from the bank register and cpu_addr_i; the hotspot access itself reads from the old bank.
REQ-026 A non-hotspot address, or a strobe absent at a hotspot address, SHALL leave bank unchanged.
REQ-027 A load write and a hotspot strobe in the same cycle SHALL both take effect.
- The hotspot decode uses the pre-update rom_size.
REQ-028 Bank width rule: bank SHALL never exceed the range of the active scheme (max 1 for 8K, 3 for 16K, 7 for 32K).

Reset
REQ-029 With rst_ni = 0 at a clk_i edge, bank SHALL become 0, so rom_addr_o = {000, cpu_addr_i[11:0]}.
REQ-030 rom_size SHALL NOT be affected by rst_ni, because images load while the CPU is held in reset.
- Its power-up (register-initial) value SHALL be 000.
REQ-031 Reset SHALL take priority over a simultaneous hotspot; a load write in a reset cycle SHALL still update rom_size.
REQ-032 sc_we_o and sc_rd_sel_o are combinational; with reset asserted they follow REQ-034 unchanged.

Configuration
REQ-033 Macro CART_SUPERCHIP_EN SHALL compile in the Superchip decode described in REQ-034.
REQ-034 With CART_SUPERCHIP_EN defined:
- sc_rd_sel_o = sc_enable_i & cpu_addr_i[12] & (cpu_addr_i[11:8] == 0) & cpu_addr_i[7], i.e. read port $1080-$10FF.
- sc_we_o = sc_enable_i & cpu_strobe_i & ~cpu_rnw_i & cpu_addr_i[12] & (cpu_addr_i[11:7] == 0), i.e. write port $1000-$107F.
REQ-035 With CART_SUPERCHIP_EN undefined: sc_rd_sel_o, sc_we_o and sc_addr_o SHALL be constant 0, and sc_enable_i SHALL be ignored.

Verification
REQ-036 Load writes at addresses 0 then $7FFF -> rom_size_o = 111; a later load write at 0 -> rom_size_o = 000.
REQ-037 Size 011, strobe read at $1FF8 -> bank_o = 2 the next clk_i, rom_addr_o = $2xxx.
- The same address with cpu_strobe_i = 0 -> bank_o unchanged.
REQ-038 Size 001, mode_f8_i = 0, strobe at $11FE -> bank_o = 1.
- Strobe at $1FF8 -> bank_o unchanged (1).
REQ-039 Size 111 with bank 5, rst_ni = 0 for one clk_i -> bank_o = 0, rom_size_o remains 111.
REQ-040 With CART_SUPERCHIP_EN defined and sc_enable_i = 1:
- strobe write to $1005 -> sc_we_o = 1, sc_addr_o = 5;
- read of $1085 -> sc_rd_sel_o = 1, sc_we_o = 0;
- with the macro undefined, both outputs stay 0.
